// File: rtl/hdmi_pkg.sv
// Shared types, 1080p60 default timing and helpers
// for the HDMI video timing generator.
package hdmi_pkg;

  localparam int H_ACTIVE_DEF = 1920;
  localparam int H_FP_DEF     = 88;
  localparam int H_SYNC_DEF   = 44;
  localparam int H_BP_DEF     = 148;
  localparam int V_ACTIVE_DEF = 1080;
  localparam int V_FP_DEF     = 4;
  localparam int V_SYNC_DEF   = 5;
  localparam int V_BP_DEF     = 36;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK,
    ST_SETTLE,
    ST_RUN
  } state_e;

  typedef struct packed {
    logic [10:0] v;
    logic [11:0] h;
  } pos_t;

  typedef struct packed {
    logic        de;
    logic [11:0] x;
    logic [10:0] y;
  } pix_t;

  function automatic int span_total(
    input int act,
    input int fp,
    input int sync,
    input int bp
  );
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous
// level flag; reset clears both stages.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/hdmi_video_timing.sv
// Video timing generator gated by PLL lock + settle.
// Define HDMI_TIMING_PREFETCH_EN for the req/req_x/req_y lead outputs.
module hdmi_video_timing
  import hdmi_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter bit SYNC_POL = 1'b1,
  parameter int SETTLE   = 1024,
  parameter int PREFETCH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pll_locked,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] x,
  output logic [10:0] y,
  output logic        frame_start,
  output logic        running
`ifdef HDMI_TIMING_PREFETCH_EN
  ,
  output logic        req,
  output logic [11:0] req_x,
  output logic [10:0] req_y
`endif
);

  localparam int H_TOTAL =
    span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL =
    span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int SW = $clog2(SETTLE + 1);

  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam int HS_BEG = H_ACTIVE + H_FP;
  localparam int HS_END = HS_BEG + H_SYNC;
  localparam int VS_BEG = V_ACTIVE + V_FP;
  localparam int VS_END = VS_BEG + V_SYNC;

  if (H_TOTAL > 4096) begin : g_h_chk
    $error("H_TOTAL exceeds 4096");
  end
  if (V_TOTAL > 2048) begin : g_v_chk
    $error("V_TOTAL exceeds 2048");
  end
  if (SETTLE < 2) begin : g_s_chk
    $error("SETTLE must be at least 2");
  end
  if (PREFETCH < 0 || PREFETCH >= H_TOTAL * V_TOTAL) begin : g_p_chk
    $error("PREFETCH must lie within one frame");
  end

  function automatic pos_t step(input pos_t p);
    pos_t n;
    n = p;
    if (p.h == H_LAST) begin
      n.h = '0;
      n.v = (p.v == V_LAST) ? '0 : p.v + 11'd1;
    end else begin
      n.h = p.h + 12'd1;
    end
    return n;
  endfunction

  function automatic pix_t pix_decode(
    input logic        en,
    input logic [11:0] h,
    input logic [10:0] v
  );
    pix_t p;
    p = '0;
    if (en && 32'(h) < H_ACTIVE && 32'(v) < V_ACTIVE) begin
      p.de = 1'b1;
      p.x  = h;
      p.y  = v;
    end
    return p;
  endfunction

  logic          lk;
  state_e        state_q, state_d;
  logic [SW-1:0] cnt_q, cnt_d;
  pos_t          pos_q, pos_d;
  pix_t          pix_q, pix_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          fs_q, fs_d;
  logic          run_ok;

  sync_2ff u_lock_sync (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .d_i    (pll_locked),
    .q_o    (lk)
  );

  // Counter enters SETTLE at 1 so RUN lands SETTLE cycles after lk rises.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      ST_WAIT_LOCK: begin
        if (lk) begin
          state_d = ST_SETTLE;
          cnt_d   = SW'(1);
        end
      end
      ST_SETTLE: begin
        if (!lk) begin
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q >= SW'(SETTLE - 1)) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + SW'(1);
        end
      end
      ST_RUN: begin
        if (!lk) state_d = ST_WAIT_LOCK;
      end
      default: state_d = ST_WAIT_LOCK;
    endcase
  end

  // Gating on lk drops outputs on the same edge RUN is left.
  assign run_ok = (state_q == ST_RUN) && lk;

  always_comb begin
    pos_d = '0;
    if (run_ok) pos_d = step(pos_q);
    pix_d = pix_decode(run_ok, pos_q.h, pos_q.v);
    hs_d  = ~SYNC_POL;
    vs_d  = ~SYNC_POL;
    fs_d  = 1'b0;
    if (run_ok) begin
      if (32'(pos_q.h) >= HS_BEG && 32'(pos_q.h) < HS_END)
        hs_d = SYNC_POL;
      if (32'(pos_q.v) >= VS_BEG && 32'(pos_q.v) < VS_END)
        vs_d = SYNC_POL;
      fs_d = (pos_q == '0);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_WAIT_LOCK;
      cnt_q   <= '0;
      pos_q   <= '0;
      pix_q   <= '0;
      hs_q    <= ~SYNC_POL;
      vs_q    <= ~SYNC_POL;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      pix_q   <= pix_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      fs_q    <= fs_d;
    end
  end

  assign de          = pix_q.de;
  assign x           = pix_q.x;
  assign y           = pix_q.y;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign frame_start = fs_q;
  assign running     = (state_q == ST_RUN);

`ifdef HDMI_TIMING_PREFETCH_EN
  localparam pos_t PF_POS = {
    11'((PREFETCH / H_TOTAL) % V_TOTAL),
    12'(PREFETCH % H_TOTAL)
  };

  pos_t lead_q, lead_d;
  pix_t req_q, req_d;

  always_comb begin
    lead_d = run_ok ? step(lead_q) : PF_POS;
    req_d  = pix_decode(run_ok, lead_q.h, lead_q.v);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lead_q <= PF_POS;
      req_q  <= '0;
    end else begin
      lead_q <= lead_d;
      req_q  <= req_d;
    end
  end

  assign req   = req_q.de;
  assign req_x = req_q.x;
  assign req_y = req_q.y;
`endif

endmodule

// File: tb/tb_hdmi_video_timing.sv
// Scoreboard bench for hdmi_video_timing on a small raster,
// one instance per sync polarity.
`timescale 1ns/1ps
module tb_hdmi_video_timing;

  localparam int HA = 16, HF = 4, HS = 3, HB = 5;
  localparam int VA = 6, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FR = HT * VT;
  localparam int ST = 16;
  localparam int PF = 8;

  logic clk = 1'b0;
  logic reset_n;
  logic pll_locked;
  logic de0, hs0, vs0, fs0, run0;
  logic de1, hs1, vs1, fs1, run1;
  logic [11:0] x0, x1;
  logic [10:0] y0, y1;
`ifdef HDMI_TIMING_PREFETCH_EN
  logic req0, req1;
  logic [11:0] rx0, rx1;
  logic [10:0] ry0, ry1;
`endif

  always #5 clk = ~clk;

  hdmi_video_timing #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b1), .SETTLE(ST), .PREFETCH(PF)
  ) u0 (
    .clk(clk), .reset_n(reset_n), .pll_locked(pll_locked),
    .de(de0), .hsync(hs0), .vsync(vs0), .x(x0), .y(y0),
    .frame_start(fs0), .running(run0)
`ifdef HDMI_TIMING_PREFETCH_EN
    , .req(req0), .req_x(rx0), .req_y(ry0)
`endif
  );

  hdmi_video_timing #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0), .SETTLE(ST), .PREFETCH(PF)
  ) u1 (
    .clk(clk), .reset_n(reset_n), .pll_locked(pll_locked),
    .de(de1), .hsync(hs1), .vsync(vs1), .x(x1), .y(y1),
    .frame_start(fs1), .running(run1)
`ifdef HDMI_TIMING_PREFETCH_EN
    , .req(req1), .req_x(rx1), .req_y(ry1)
`endif
  );

  typedef struct {
    int          cyc;
    logic [27:0] e0;
    logic [27:0] e1;
    logic [23:0] ep;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int first_run = -1, first_fs = -1;
  int de_cnt = 0, fs_cnt = 0, hs_cnt = 0, vs_cnt = 0;
  int c0, c1, c2;

  logic m_s1, m_lk, m_run, m_act;
  int   m_sc, m_pos;

  function automatic logic [27:0] expect_vid(
    input logic run, input logic act,
    input int pos, input logic pol
  );
    int h, v;
    logic d, ha, va;
    h = pos % HT;
    v = pos / HT;
    if (!act) return {run, 1'b0, ~pol, ~pol, 1'b0, 12'd0, 11'd0};
    d  = (h < HA) && (v < VA);
    ha = (h >= HA + HF) && (h < HA + HF + HS);
    va = (v >= VA + VF) && (v < VA + VF + VS);
    return {run, d, ha ? pol : ~pol, va ? pol : ~pol,
            (h == 0 && v == 0),
            d ? 12'(h) : 12'd0, d ? 11'(v) : 11'd0};
  endfunction

  function automatic logic [23:0] expect_pf(
    input logic act, input int pos
  );
    int p, h, v;
    logic d;
    p = (pos + PF) % FR;
    h = p % HT;
    v = p / HT;
    d = act && (h < HA) && (v < VA);
    return {d, d ? 12'(h) : 12'd0, d ? 11'(v) : 11'd0};
  endfunction

  task automatic model_reset();
    m_s1 = 0; m_lk = 0; m_run = 0; m_act = 0;
    m_sc = 0; m_pos = 0;
  endtask

  // running(n) needs lk high over the previous ST cycles;
  // outputs at n decode position counted from the first cycle after RUN.
  task automatic tick(input logic l);
    logic act_n;
    exp_t r;
    pll_locked = l;
    @(posedge clk);
    #1;
    act_n = m_run && m_lk;
    m_pos = act_n ? (m_act ? (m_pos + 1) % FR : 0) : 0;
    m_act = act_n;
    m_sc  = m_lk ? m_sc + 1 : 0;
    m_run = (m_sc >= ST);
    m_lk  = m_s1;
    m_s1  = l;
    cyc++;
    r.cyc = cyc;
    r.e0  = expect_vid(m_run, m_act, m_pos, 1'b1);
    r.e1  = expect_vid(m_run, m_act, m_pos, 1'b0);
    r.ep  = expect_pf(m_act, m_pos);
    q.push_back(r);
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      assert ({run0, de0, hs0, vs0, fs0, x0, y0} === e.e0) else begin
        errors++;
        $error("FAIL vid_pol1 cyc=%0d got=%h exp=%h", e.cyc,
               {run0, de0, hs0, vs0, fs0, x0, y0}, e.e0);
      end
      checks++;
      assert ({run1, de1, hs1, vs1, fs1, x1, y1} === e.e1) else begin
        errors++;
        $error("FAIL vid_pol0 cyc=%0d got=%h exp=%h", e.cyc,
               {run1, de1, hs1, vs1, fs1, x1, y1}, e.e1);
      end
`ifdef HDMI_TIMING_PREFETCH_EN
      checks++;
      assert ({req0, rx0, ry0} === e.ep) else begin
        errors++;
        $error("FAIL req_pol1 cyc=%0d got=%h exp=%h", e.cyc,
               {req0, rx0, ry0}, e.ep);
      end
      checks++;
      assert ({req1, rx1, ry1} === e.ep) else begin
        errors++;
        $error("FAIL req_pol0 cyc=%0d got=%h exp=%h", e.cyc,
               {req1, rx1, ry1}, e.ep);
      end
`endif
      if (run0 === 1'b1 && first_run < 0) first_run = e.cyc;
      if (fs0 === 1'b1 && first_fs < 0) first_fs = e.cyc;
      de_cnt += int'(de0 === 1'b1);
      fs_cnt += int'(fs0 === 1'b1);
      hs_cnt += int'(hs0 === 1'b1);
      vs_cnt += int'(vs0 === 1'b1);
    end
  end

  initial begin
    reset_n    = 1'b0;
    pll_locked = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pol1", int'({run0, de0, hs0, vs0, fs0, x0, y0}),
        int'(expect_vid(1'b0, 1'b0, 0, 1'b1)));
    chk("rst_pol0", int'({run1, de1, hs1, vs1, fs1, x1, y1}),
        int'(expect_vid(1'b0, 1'b0, 0, 1'b0)));
`ifdef HDMI_TIMING_PREFETCH_EN
    chk("rst_req", int'({req0, rx0, ry0}), 0);
`endif
    #2 reset_n = 1'b1;
    repeat (4) tick(1'b0);

    // Startup: lock rises, settle, first frame.
    c0 = cyc;
    first_run = -1;
    first_fs  = -1;
    repeat (ST + 3) tick(1'b1);
    de_cnt = 0; fs_cnt = 0; hs_cnt = 0; vs_cnt = 0;
    repeat (FR - 1) tick(1'b1);
    @(negedge clk);
    #1;
    chk("run_rise", first_run - c0, ST + 2);
    chk("first_fs", first_fs - c0, ST + 3);
    chk("de_per_frame", de_cnt, HA * VA);
    chk("fs_per_frame", fs_cnt, 1);
    chk("hs_per_frame", hs_cnt, HS * VT);
    chk("vs_per_frame", vs_cnt, VS * HT);

    // Lock loss mid-frame, then relock.
    repeat (3 * HT + 10) tick(1'b1);
    repeat (25) tick(1'b0);
    c1 = cyc;
    first_fs = -1;
    repeat (ST + 3 + 2 * HT) tick(1'b1);
    chk("relock_fs", first_fs - c1, ST + 3);

    // Lock glitch during settle restarts the count.
    repeat (10) tick(1'b0);
    repeat (12) tick(1'b1);
    tick(1'b0);
    c2 = cyc;
    first_run = -1;
    repeat (ST + 10) tick(1'b1);
    chk("glitch_run", first_run - c2, ST + 2);
    repeat (FR + 20) tick(1'b1);

    // Asynchronous reset mid-frame.
    #2 reset_n = 1'b0;
    q.delete();
    #1;
    chk("arst_pol1", int'({run0, de0, hs0, vs0, fs0, x0, y0}),
        int'(expect_vid(1'b0, 1'b0, 0, 1'b1)));
    chk("arst_pol0", int'({run1, de1, hs1, vs1, fs1, x1, y1}),
        int'(expect_vid(1'b0, 1'b0, 0, 1'b0)));
`ifdef HDMI_TIMING_PREFETCH_EN
    chk("arst_req", int'({req0, rx0, ry0}), 0);
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    repeat (ST + 3 + 2 * HT) tick(1'b1);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
